mem_port_ctrl: RTL and testbench



---
 rtl/memport_pkg.sv | 15 +
 rtl/flopenr.sv | 18 +
 rtl/memport_timer.sv | 25 ++
 rtl/mem_port_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/memport_pkg.sv
// Shared types and constants for the memory-port controller and its timer.
package memport_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   // Width of the BUSY-cycle counter; covers TIMEOUT values up to 255.
   localparam int TIMER_W = 8;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/flopenr.sv
// Enable flop with synchronous active-high reset.
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load d when enabled, clear on reset.
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/memport_timer.sv
// BUSY-cycle counter for the memory port. tc is raised during the
// TIMEOUT-th enabled cycle since the last clear.
module memport_timer
   import memport_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [TIMER_W-1:0] r_count;

   // Count enabled cycles; clear between accesses.
   always_ff @(posedge clk) begin
      if (reset || clr) r_count <= '0;
      else if (en)      r_count <= r_count + TIMER_W'(1);
   end

   assign tc = en && (r_count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: selects PC or ALUOut, runs a req/ack access on a
// variable-latency bus, captures Instr/Data and stalls the multicycle
// controller until the access completes. Accesses that see no ack within
// TIMEOUT BUSY cycles are aborted with a bus_err pulse.
// Build option MEMPORT_ALIGN_CHECK_EN: misaligned addresses are rejected
// with an align_err pulse and no bus request; otherwise the low two address
// bits are forced to zero and align_err is tied 0.
module mem_port_ctrl
   import memport_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic              ir_wr,
   input  logic              adr_src,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] data,
   output logic              stall,
   output logic              bus_err,
   output logic              align_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_t            r_state, w_next;
   logic              w_req;
   logic [ADDR_W-1:0] w_sel_addr, w_lat_addr;
   logic              w_misaligned;
   logic              w_latch, w_cap, w_timeout, w_align_hit;
   logic              w_tmr_en, w_tmr_clr, w_tc;
   logic              r_we, r_fetch;
   logic              r_bus_err;
   logic [DATA_W-1:0] w_data_d;

   assign w_req      = rd_req | wr_req;
   assign w_sel_addr = adr_src ? alu_out : pc;

`ifdef MEMPORT_ALIGN_CHECK_EN
   logic r_align_err;

   assign w_lat_addr   = w_sel_addr;
   assign w_misaligned = |w_sel_addr[1:0];

   // One-cycle align_err pulse, visible during the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) r_align_err <= 1'b0;
      else       r_align_err <= w_align_hit;
   end

   assign align_err = r_align_err;
`else
   assign w_lat_addr   = w_sel_addr & ~ADDR_W'(3);
   assign w_misaligned = 1'b0;
   assign align_err    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state, stall and per-cycle strobes.
   always_comb begin
      w_next      = r_state;
      stall       = 1'b0;
      w_latch     = 1'b0;
      w_cap       = 1'b0;
      w_timeout   = 1'b0;
      w_align_hit = 1'b0;
      w_tmr_en    = 1'b0;
      w_tmr_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            stall = w_req;
            if (w_req) begin
               if (w_misaligned) begin
                  w_align_hit = 1'b1;
                  w_next      = DONE;
               end else begin
                  w_latch = 1'b1;
                  w_next  = BUSY;
               end
            end
         end
         BUSY: begin
            stall    = 1'b1;
            w_tmr_en = 1'b1;
            if (mem_ack) begin
               // Ack beats a coincident timeout; writes update nothing.
               w_cap  = ~r_we;
               w_next = DONE;
            end else if (w_tc) begin
               w_timeout = 1'b1;
               w_next    = DONE;
            end
         end
         DONE: begin
            w_tmr_clr = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // One-cycle bus_err pulse, visible during the DONE cycle.
   always_ff @(posedge clk) begin
      if (reset) r_bus_err <= 1'b0;
      else       r_bus_err <= w_timeout;
   end

   memport_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (w_tmr_clr),
      .en    (w_tmr_en),
      .tc    (w_tc)
   );

   // Access latch: address, store data and access kind, held through BUSY.
   // A simultaneous write request wins, so a fetch is only a pure read.
   flopenr #(.WIDTH(ADDR_W)) u_addr (
      .clk(clk), .reset(reset), .en(w_latch), .d(w_lat_addr), .q(mem_addr)
   );
   flopenr #(.WIDTH(DATA_W)) u_wdata (
      .clk(clk), .reset(reset), .en(w_latch), .d(wdata), .q(mem_wdata)
   );
   flopenr #(.WIDTH(2)) u_kind (
      .clk(clk), .reset(reset), .en(w_latch),
      .d({wr_req, ir_wr & ~wr_req}), .q({r_we, r_fetch})
   );

   // Result registers: Data on every completed read (zero on timeout),
   // Instr only on a completed fetch.
   assign w_data_d = w_timeout ? DATA_W'(ZERO_WORD) : mem_rdata;

   flopenr #(.WIDTH(DATA_W)) u_data (
      .clk(clk), .reset(reset), .en(w_cap | w_timeout), .d(w_data_d), .q(data)
   );
   flopenr #(.WIDTH(DATA_W)) u_instr (
      .clk(clk), .reset(reset), .en(w_cap & r_fetch), .d(mem_rdata), .q(instr)
   );

   assign mem_req = (r_state == BUSY);
   assign mem_we  = r_we & mem_req;
   assign bus_err = r_bus_err;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed testbench for mem_port_ctrl with hand-computed expectations.
// Build option MEMPORT_ALIGN_CHECK_EN selects the misalignment scenario.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req, wr_req, ir_wr, adr_src;
   logic [31:0] pc, alu_out, wdata;
   logic [31:0] instr, data;
   logic        stall, bus_err, align_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int n_checks = 0;
   int n_errors = 0;
   int busy_cycles;

   always #5 clk = ~clk;

   mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .ir_wr     (ir_wr),
      .adr_src   (adr_src),
      .pc        (pc),
      .alu_out   (alu_out),
      .wdata     (wdata),
      .instr     (instr),
      .data      (data),
      .stall     (stall),
      .bus_err   (bus_err),
      .align_err (align_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset = 1'b1; rd_req = 0; wr_req = 0; ir_wr = 0; adr_src = 0;
      pc = 0; alu_out = 0; wdata = 0; mem_rdata = 0; mem_ack = 0;
      tick(); tick();
      reset = 1'b0;
      settle();
      chk_eq("rst_mem_req",  mem_req, 0);
      chk_eq("rst_mem_we",   mem_we, 0);
      chk_eq("rst_mem_addr", mem_addr, 0);
      chk_eq("rst_mem_wdat", mem_wdata, 0);
      chk_eq("rst_instr",    instr, 0);
      chk_eq("rst_data",     data, 0);
      chk_eq("rst_bus_err",  bus_err, 0);
      chk_eq("rst_align",    align_err, 0);
      chk_eq("rst_stall",    stall, 0);

      // Fetch: ack one cycle after mem_req.
      tick();
      pc = 32'h0000_0010; ir_wr = 1; rd_req = 1; adr_src = 0;
      settle();
      chk_eq("f_stall_N", stall, 1);
      chk_eq("f_req_N", mem_req, 0);
      tick();
      chk_eq("f_req_N1", mem_req, 1);
      chk_eq("f_addr", mem_addr, 32'h10);
      chk_eq("f_we", mem_we, 0);
      chk_eq("f_stall_N1", stall, 1);
      tick();
      mem_ack = 1; mem_rdata = 32'hE280_0001;
      settle();
      chk_eq("f_stall_N2", stall, 1);
      tick();
      mem_ack = 0; mem_rdata = 32'h0;
      settle();
      chk_eq("f_stall_N3", stall, 0);
      chk_eq("f_req_N3", mem_req, 0);
      chk_eq("f_instr", instr, 32'hE280_0001);
      chk_eq("f_data", data, 32'hE280_0001);
      tick();
      rd_req = 0; ir_wr = 0;
      settle();
      chk_eq("f_idle_stall", stall, 0);
      chk_eq("f_idle_req", mem_req, 0);

      // Ack outside BUSY must not touch the result registers.
      mem_ack = 1; mem_rdata = 32'h5555_5555;
      tick();
      mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("stray_ack_data", data, 32'hE280_0001);
      chk_eq("stray_ack_req", mem_req, 0);

      // Load from ALUOut with ack on the third bus cycle.
      adr_src = 1; alu_out = 32'h0000_0080; rd_req = 1;
      tick();
      chk_eq("l_addr", mem_addr, 32'h80);
      chk_eq("l_req", mem_req, 1);
      tick();
      tick();
      mem_ack = 1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("l_stall", stall, 0);
      chk_eq("l_data", data, 32'h1234_5678);
      chk_eq("l_instr", instr, 32'hE280_0001);
      tick();
      rd_req = 0;

      // Store: write data held even if the input changes.
      adr_src = 1; alu_out = 32'h0000_0084; wdata = 32'hCAFE_F00D; wr_req = 1;
      tick();
      wdata = 32'h0;
      settle();
      chk_eq("s_we", mem_we, 1);
      chk_eq("s_addr", mem_addr, 32'h84);
      chk_eq("s_wdata1", mem_wdata, 32'hCAFE_F00D);
      tick();
      chk_eq("s_wdata2", mem_wdata, 32'hCAFE_F00D);
      mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("s_stall", stall, 0);
      chk_eq("s_data", data, 32'h1234_5678);
      chk_eq("s_instr", instr, 32'hE280_0001);
      tick();
      wr_req = 0;

      // Read and write together: one write, minimum latency.
      adr_src = 0; pc = 32'h0000_0020; wdata = 32'h1111_2222;
      rd_req = 1; wr_req = 1; ir_wr = 1;
      tick();
      chk_eq("rw_we", mem_we, 1);
      chk_eq("rw_wdata", mem_wdata, 32'h1111_2222);
      mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("rw_stall_N2", stall, 0);
      chk_eq("rw_data", data, 32'h1234_5678);
      chk_eq("rw_instr", instr, 32'hE280_0001);
      tick();
      rd_req = 0; wr_req = 0; ir_wr = 0;
      tick();
      chk_eq("rw_single", mem_req, 0);

      // Timeout: no ack at all.
      adr_src = 1; alu_out = 32'h0000_0090; rd_req = 1;
      tick();
      busy_cycles = 0;
      while (mem_req && busy_cycles < 40) begin
         busy_cycles++;
         tick();
      end
      chk_eq("to_cycles", busy_cycles, 15);
      chk_eq("to_bus_err", bus_err, 1);
      chk_eq("to_data", data, 32'h0);
      chk_eq("to_instr", instr, 32'hE280_0001);
      chk_eq("to_stall", stall, 0);
      tick();
      rd_req = 0;
      settle();
      chk_eq("to_err_pulse", bus_err, 0);
      chk_eq("to_idle_req", mem_req, 0);

      // Reset in the middle of a fetch.
      adr_src = 0; pc = 32'h0000_0040; rd_req = 1; ir_wr = 1;
      tick();
      chk_eq("r_req_busy", mem_req, 1);
      reset = 1; rd_req = 0; ir_wr = 0;
      mem_ack = 1; mem_rdata = 32'h7777_7777;
      tick();
      reset = 0; mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("r_req", mem_req, 0);
      chk_eq("r_instr", instr, 0);
      chk_eq("r_data", data, 0);
      chk_eq("r_addr", mem_addr, 0);
      tick();
      chk_eq("r_idle", mem_req, 0);

      // Misaligned data address.
      adr_src = 1; alu_out = 32'h0000_0082; rd_req = 1;
`ifdef MEMPORT_ALIGN_CHECK_EN
      tick();
      chk_eq("a_err", align_err, 1);
      chk_eq("a_req", mem_req, 0);
      chk_eq("a_stall", stall, 0);
      tick();
      rd_req = 0;
      settle();
      chk_eq("a_pulse", align_err, 0);
      chk_eq("a_req2", mem_req, 0);
      chk_eq("a_data", data, 0);
`else
      tick();
      chk_eq("a_forced_addr", mem_addr, 32'h80);
      chk_eq("a_err_tied", align_err, 0);
      mem_ack = 1; mem_rdata = 32'hA5A5_0000;
      tick();
      mem_ack = 0; mem_rdata = 0;
      settle();
      chk_eq("a_data", data, 32'hA5A5_0000);
      tick();
      rd_req = 0;
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
